// File: rtl/user_io_pkg.sv
// user_io_pkg: register map and counter sizing shared by the user-I/O PIO
package user_io_pkg;
  localparam logic [2:0] REG_DATA = 3'd0;
  localparam logic [2:0] REG_EDGE = 3'd1;
  localparam logic [2:0] REG_MASK = 3'd2;
  localparam logic [2:0] REG_LED  = 3'd3;
  localparam logic [2:0] REG_MODE = 3'd4;
  function automatic int dbc_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction
endpackage

// File: rtl/user_io_debounce.sv
// user_io_debounce: one input channel -- 2-flop synchroniser, stability counter, stable flop, change pulse
module user_io_debounce
  import user_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic stable_o,
  output logic chg_o
);
  localparam int CW = dbc_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);
  logic sync1_q, sync2_q, stable_q;
  logic [CW-1:0] cnt_q, cnt_d;
  // Flip once the mismatch has already persisted LIMIT cycles; counter restarts on any match or flip
  always_comb begin
    chg_o = (sync2_q != stable_q) && (cnt_q == LIMIT);
    cnt_d = (sync2_q == stable_q || chg_o) ? '0 : cnt_q + CW'(1);
  end
  // Synchroniser, stable value and counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= in_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_q ^ chg_o;
      cnt_q    <= cnt_d;
    end
  end
  assign stable_o = stable_q;
endmodule

// File: rtl/user_io_pio.sv
// user_io_pio: debounced inputs with edge capture/irq, LEDs with optional blink (USER_IO_BLINK_EN), register slave
module user_io_pio
  import user_io_pkg::*;
#(
  parameter int NUM_IN          = 8,
  parameter int NUM_LED         = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_CYCLES    = 25000000
) (
  input  logic               system_clock,
  input  logic               system_reset,
  input  logic [NUM_IN-1:0]  pio_in,
  output logic [NUM_LED-1:0] led_out,
  input  logic [2:0]         address,
  input  logic               read,
  input  logic               write,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               irq
);
  logic [NUM_IN-1:0]  stable, chg;
  logic [NUM_IN-1:0]  edge_q, edge_d, mask_q, mask_d;
  logic [NUM_LED-1:0] led_q, led_d, ledout_q, ledout_d, mode_rd;
  logic [31:0]        rdata_q, rdata_d;
  logic               irq_q;
  logic               unused_wd;
  for (genvar i = 0; i < NUM_IN; i++) begin : g_deb
    user_io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk      (system_clock),
      .rst      (system_reset),
      .in_i     (pio_in[i]),
      .stable_o (stable[i]),
      .chg_o    (chg[i])
    );
  end
`ifdef USER_IO_BLINK_EN
  localparam int PW = dbc_width(BLINK_CYCLES);
  localparam logic [PW-1:0] PMAX = PW'(BLINK_CYCLES - 1);
  logic [NUM_LED-1:0] mode_q, mode_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic               phase_q, wrap;
  // Blink square wave: phase toggles each time the prescaler wraps
  always_comb begin
    wrap     = pre_q == PMAX;
    pre_d    = wrap ? '0 : pre_q + PW'(1);
    mode_d   = (write && address == REG_MODE) ? writedata[NUM_LED-1:0] : mode_q;
    ledout_d = led_q & (~mode_q | {NUM_LED{phase_q}});
  end
  // Blink mode register and prescaler state
  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      mode_q  <= '0;
      pre_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      pre_q   <= pre_d;
      phase_q <= phase_q ^ wrap;
    end
  end
  assign mode_rd = mode_q;
`else
  assign ledout_d = led_q;
  assign mode_rd  = '0;
`endif
  // Register writes, edge capture (a new flip beats a same-cycle clear) and read mux of pre-write values
  always_comb begin
    edge_d  = (edge_q & ~((write && address == REG_EDGE) ? writedata[NUM_IN-1:0] : '0)) | chg;
    mask_d  = (write && address == REG_MASK) ? writedata[NUM_IN-1:0] : mask_q;
    led_d   = (write && address == REG_LED) ? writedata[NUM_LED-1:0] : led_q;
    rdata_d = !read                ? rdata_q :
              address == REG_DATA ? 32'(stable) :
              address == REG_EDGE ? 32'(edge_q) :
              address == REG_MASK ? 32'(mask_q) :
              address == REG_LED  ? 32'(led_q) :
              address == REG_MODE ? 32'(mode_rd) : '0;
  end
  // Slave registers and registered outputs
  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      edge_q   <= '0;
      mask_q   <= '0;
      led_q    <= '0;
      ledout_q <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      edge_q   <= edge_d;
      mask_q   <= mask_d;
      led_q    <= led_d;
      ledout_q <= ledout_d;
      rdata_q  <= rdata_d;
      irq_q    <= |(edge_q & mask_q);
    end
  end
  assign unused_wd = ^writedata;
  assign led_out   = ledout_q;
  assign readdata  = rdata_q;
  assign irq       = irq_q;
endmodule

// File: tb/tb_user_io_pio.sv
// tb_user_io_pio: directed stimulus, per-cycle model comparison plus literal checks for user_io_pio
module tb_user_io_pio;
  localparam int NI = 8, NL = 4, D = 16, B = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [NI-1:0] pio = '0;
  logic [2:0] addr = '0;
  logic rd = 1'b0, wr = 1'b0;
  logic [31:0] wd = '0;
  logic [NL-1:0] led;
  logic [31:0] rdata;
  logic irq;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  user_io_pio #(.NUM_IN(NI), .NUM_LED(NL), .DEBOUNCE_CYCLES(D), .BLINK_CYCLES(B)) dut (
    .system_clock (clk),
    .system_reset (rst),
    .pio_in       (pio),
    .led_out      (led),
    .address      (addr),
    .read         (rd),
    .write        (wr),
    .writedata    (wd),
    .readdata     (rdata),
    .irq          (irq)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: an input flips once its last D+1 synchronised samples all differ from the stable value
  logic [NI-1:0] smp[$];
  logic [NI-1:0] m_data, m_edge, m_mask, flip;
  logic [NL-1:0] m_led, m_mode, m_lo;
  logic [31:0] m_rd;
  logic m_irq, m_phase;
  int m_cyc;
  bit m_valid = 0;
  function automatic logic [31:0] regval(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_data);
      3'd1: return 32'(m_edge);
      3'd2: return 32'(m_mask);
      3'd3: return 32'(m_led);
      3'd4: return 32'(m_mode);
      default: return 32'd0;
    endcase
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      smp = {};
      repeat (D + 2) smp.push_back('0);
      m_data = '0; m_edge = '0; m_mask = '0; m_led = '0; m_mode = '0; m_lo = '0;
      m_rd = '0; m_irq = 1'b0; m_cyc = 0; m_valid = 1;
    end else begin
      flip = '0;
      for (int i = 0; i < NI; i++) begin
        bit ok;
        ok = 1;
        for (int j = 1; j <= D + 1; j++) if (smp[j][i] == m_data[i]) ok = 0;
        flip[i] = ok;
      end
      m_rd = rd ? regval(addr) : m_rd;
      m_irq = |(m_edge & m_mask);
      m_phase = ((m_cyc / B) % 2) == 1;
      m_lo = m_led & (~m_mode | {NL{m_phase}});
      m_edge = (m_edge & ~((wr && addr == 3'd1) ? wd[NI-1:0] : '0)) | flip;
      m_data = m_data ^ flip;
      if (wr && addr == 3'd2) m_mask = wd[NI-1:0];
      if (wr && addr == 3'd3) m_led = wd[NL-1:0];
`ifdef USER_IO_BLINK_EN
      if (wr && addr == 3'd4) m_mode = wd[NL-1:0];
`endif
      smp.push_front(pio);
      void'(smp.pop_back());
      m_cyc++;
    end
  end
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_readdata", rdata, m_rd);
      chk("model_led_out", 32'(led), 32'(m_lo));
      chk("model_irq", 32'(irq), 32'(m_irq));
    end
  end
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic wreg(input logic [2:0] a, input logic [31:0] d);
    addr = a; wd = d; wr = 1'b1;
    cyc();
    wr = 1'b0;
  endtask
  task automatic rreg(input logic [2:0] a, output logic [31:0] v);
    addr = a; rd = 1'b1;
    cyc();
    rd = 1'b0;
    v = rdata;
  endtask
  initial begin
    logic [31:0] v;
    int changes;
    logic prev;
    cyc(3);
    rst = 1'b0;
    cyc();
    for (int a = 0; a < 8; a++) begin
      rreg(3'(a), v);
      chk($sformatf("reset_read_%0d", a), v, 32'd0);
    end
    chk("reset_led", 32'(led), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    wreg(3'd2, 32'h01);
    addr = 3'd0; rd = 1'b1; pio[0] = 1'b1;
    cyc(19);
    chk("latency_data_before", rdata, 32'd0);
    chk("latency_irq_before", 32'(irq), 32'd0);
    cyc();
    chk("latency_data", rdata, 32'h01);
    chk("latency_irq", 32'(irq), 32'd1);
    rd = 1'b0;
    rreg(3'd1, v);
    chk("edge_set", v, 32'h01);
    pio[3] = 1'b1;
    cyc(10);
    pio[3] = 1'b0;
    cyc(30);
    rreg(3'd0, v);
    chk("glitch_data", v, 32'h01);
    rreg(3'd1, v);
    chk("glitch_edge", v, 32'h01);
    chk("glitch_irq", 32'(irq), 32'd1);
    wreg(3'd1, 32'h01);
    chk("clear_irq_hold", 32'(irq), 32'd1);
    cyc();
    chk("clear_irq_drop", 32'(irq), 32'd0);
    rreg(3'd1, v);
    chk("edge_cleared", v, 32'd0);
    pio[0] = 1'b0;
    cyc(18);
    wreg(3'd1, 32'h01);
    rreg(3'd1, v);
    chk("edge_set_wins", v, 32'h01);
    rreg(3'd0, v);
    chk("falling_data", v, 32'd0);
    wreg(3'd3, 32'hF);
    wreg(3'd4, 32'h5);
    cyc(2);
`ifdef USER_IO_BLINK_EN
    rreg(3'd4, v);
    chk("mode_read", v, 32'h5);
    changes = 0;
    prev = led[0];
    for (int n = 0; n < 32; n++) begin
      cyc();
      chk("blink_steady_bits", 32'({led[3], led[1]}), 32'h3);
      chk("blink_pair", 32'(led[2]), 32'(led[0]));
      if (led[0] != prev) changes++;
      prev = led[0];
    end
    chk("blink_toggles", 32'(changes), 32'd4);
`else
    chk("led_static", 32'(led), 32'hF);
    rreg(3'd4, v);
    chk("mode_read_zero", v, 32'd0);
`endif
    pio[1] = 1'b1;
    cyc(12);
    rst = 1'b1; pio = '0;
    cyc(2);
    rst = 1'b0;
    cyc(20);
    for (int a = 0; a < 8; a++) begin
      rreg(3'(a), v);
      chk($sformatf("midreset_read_%0d", a), v, 32'd0);
    end
    chk("midreset_led", 32'(led), 32'd0);
    chk("midreset_irq", 32'(irq), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
